// File: rtl/trig_pkg.sv
// trig_pkg: state encoding shared by the pulse generator, monitors and testbench.
package trig_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DELAY = ST_DELAY,
    HIGH  = ST_HIGH,
    HOLD  = ST_HOLD
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [DW-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + DW'(1);
endmodule

// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: delayed, fixed-width output pulse per accepted trigger, with holdoff
// and a saturating count of triggers that arrive while busy.
module trig_pulse_gen import trig_pkg::*; #(
  parameter int CW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          trig_in,
  input  logic [CW-1:0] delay,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] holdoff,
  output logic          pulse_out,
  output logic          busy,
  output logic [DW-1:0] dropped
);
  state_t state;
  logic [CW-1:0] cnt, w_q, h_q, w_eff;
  logic done;
  assign w_eff = (width == '0) ? CW'(1) : width;
  assign done = cnt == CW'(1);
  // the delay setting goes straight into the counter; width and holdoff are kept for later phases
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      w_q <= '0;
      h_q <= '0;
      pulse_out <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable && trig_in) begin
          w_q <= w_eff;
          h_q <= holdoff;
          busy <= 1'b1;
          if (delay == '0) begin
            state <= HIGH;
            cnt <= w_eff;
            pulse_out <= 1'b1;
          end else begin
            state <= DELAY;
            cnt <= delay;
          end
        end
        DELAY: if (!enable) begin
          state <= IDLE;
          cnt <= '0;
          busy <= 1'b0;
        end else if (done) begin
          state <= HIGH;
          cnt <= w_q;
          pulse_out <= 1'b1;
        end else cnt <= cnt - CW'(1);
        HIGH: if (done) begin
          pulse_out <= 1'b0;
          if (h_q == '0) begin
            state <= IDLE;
            cnt <= '0;
            busy <= 1'b0;
          end else begin
            state <= HOLD;
            cnt <= h_q;
          end
        end else cnt <= cnt - CW'(1);
        HOLD: if (done) begin
          state <= IDLE;
          cnt <= '0;
          busy <= 1'b0;
        end else cnt <= cnt - CW'(1);
      endcase
    end
  sat_counter #(.DW(DW)) u_dropped (
    .clk(clk),
    .reset(reset),
    .inc(trig_in && state != IDLE),
    .count(dropped)
  );
endmodule

// File: tb/tb_trig_pulse_gen.sv
// tb_trig_pulse_gen: table-driven timing vectors plus directed multi-cycle corner cases.
module tb_trig_pulse_gen;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, trig_in = 1'b0;
  logic [7:0] delay = '0, width = '0, holdoff = '0;
  logic pulse_out, busy;
  logic [3:0] dropped;
  int errors = 0, checks = 0;
  typedef struct {
    logic [7:0] d, w, h;
    int rise, high, busy_len;
  } vec_t;
  vec_t v[6];
  trig_pulse_gen #(.CW(8), .DW(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trig_in(trig_in),
    .delay(delay), .width(width), .holdoff(holdoff),
    .pulse_out(pulse_out), .busy(busy), .dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) tick();
    check("idle_timeout", int'(busy), 0);
    tick();
  endtask
  initial begin
    int rise, hi, bl, base, b3, b4;
    logic [3:0] pat;
    v[0] = '{8'd3, 8'd2, 8'd4, 3, 2, 9};
    v[1] = '{8'd0, 8'd0, 8'd0, 0, 1, 1};
    v[2] = '{8'd1, 8'd1, 8'd1, 1, 1, 3};
    v[3] = '{8'd0, 8'd5, 8'd0, 0, 5, 5};
    v[4] = '{8'd5, 8'd0, 8'd2, 5, 1, 8};
    v[5] = '{8'd255, 8'd255, 8'd255, 255, 255, 765};
    tick();
    tick();
    check("reset_pulse", int'(pulse_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_dropped", int'(dropped), 0);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    tick();
    // settings are scrambled after acceptance to prove they were latched
    foreach (v[i]) begin
      delay = v[i].d; width = v[i].w; holdoff = v[i].h;
      trig_in = 1'b1;
      rise = -1; hi = 0; bl = 0; base = int'(dropped);
      for (int k = 0; k < v[i].busy_len + 4; k++) begin
        tick();
        if (k == 0) begin
          trig_in = 1'b0; delay = 8'h77; width = 8'hAA; holdoff = 8'h55;
        end
        if (pulse_out && rise < 0) rise = k;
        hi += int'(pulse_out);
        bl += int'(busy);
      end
      check($sformatf("vec%0d_rise", i), rise, v[i].rise);
      check($sformatf("vec%0d_high", i), hi, v[i].high);
      check($sformatf("vec%0d_busy", i), bl, v[i].busy_len);
      check($sformatf("vec%0d_dropped", i), int'(dropped), base);
      tick();
    end
    delay = 8'd3; width = 8'd2; holdoff = 8'd4;
    rise = -1; base = int'(dropped); b3 = -1;
    for (int k = 0; k <= 16; k++) begin
      trig_in = (k == 0 || k == 2 || k == 9 || k == 10);
      tick();
      if (k == 9) b3 = int'(busy);
      if (k >= 10 && pulse_out && rise < 0) rise = k;
    end
    trig_in = 1'b0;
    check("b2b_busy_low_at_9", b3, 0);
    check("b2b_second_rise", rise, 13);
    check("b2b_dropped", int'(dropped) - base, 2);
    wait_idle();
    delay = 8'd0; width = 8'd0; holdoff = 8'd0;
    base = int'(dropped); pat = '0;
    for (int k = 0; k < 4; k++) begin
      trig_in = (k == 0 || k == 2);
      tick();
      pat[k] = pulse_out;
    end
    trig_in = 1'b0;
    check("zero_pattern", int'(pat), 5);
    check("zero_dropped", int'(dropped), base);
    wait_idle();
    delay = 8'd10; width = 8'd2; holdoff = 8'd3;
    hi = 0; b3 = -1; b4 = -1;
    for (int k = 0; k < 15; k++) begin
      trig_in = (k == 0);
      enable = (k < 4);
      tick();
      if (k == 3) b3 = int'(busy);
      if (k == 4) b4 = int'(busy);
      hi += int'(pulse_out);
    end
    check("abort_busy_before", b3, 1);
    check("abort_busy_after", b4, 0);
    check("abort_no_pulse", hi, 0);
    base = int'(dropped);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    tick();
    check("disabled_dropped", int'(dropped), base);
    check("disabled_busy", int'(busy), 0);
    delay = 8'd1; width = 8'd3; holdoff = 8'd2;
    hi = 0; bl = 0;
    for (int k = 0; k < 10; k++) begin
      trig_in = (k == 0);
      enable = (k < 2);
      tick();
      hi += int'(pulse_out);
      bl += int'(busy);
    end
    enable = 1'b1;
    check("en_off_high", hi, 3);
    check("en_off_busy", bl, 6);
    delay = 8'd2; width = 8'd5; holdoff = 8'd0;
    for (int k = 0; k < 3; k++) begin
      trig_in = (k <= 1);
      tick();
    end
    trig_in = 1'b0;
    check("rst_pre_pulse", int'(pulse_out), 1);
    check("rst_pre_dropped_nonzero", int'(dropped != 0), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_pulse", int'(pulse_out), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_dropped", int'(dropped), 0);
    @(negedge clk);
    reset = 1'b0;
    delay = 8'd1; width = 8'd1; holdoff = 8'd0;
    pat = '0;
    for (int k = 0; k < 3; k++) begin
      trig_in = (k == 0);
      tick();
      pat[k] = pulse_out;
    end
    trig_in = 1'b0;
    check("post_rst_pattern", int'(pat), 2);
    wait_idle();
    delay = 8'd50; width = 8'd1; holdoff = 8'd0;
    for (int k = 0; k <= 20; k++) begin
      trig_in = 1'b1;
      tick();
      if (k == 14) check("sat_count_14", int'(dropped), 14);
      if (k == 15) check("sat_count_15", int'(dropped), 15);
    end
    trig_in = 1'b0;
    check("sat_final", int'(dropped), 15);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
